// File: rtl/alu_srcb_stage_pkg.sv
// Shared pipeline definitions for the EX-stage operand-B select.
//
// Contents:
//   EXT_ZERO / EXT_SIGN / EXT_UPPER : ext_mode encodings (2'b11 is reserved, treated as sign)
//   FWD_NONE                        : fwd_sel value choosing the register-file read port
//   DEFAULT_DATA_W / DEFAULT_IMM_W  : default datapath and immediate widths
package alu_srcb_stage_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_IMM_W  = 16;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam int unsigned FWD_NONE = 0;

endpackage

// File: rtl/alu_srcb_stage_imm_extender.sv
// Immediate extender: widens an IMM_W-bit immediate field to DATA_W bits.
// Purely combinational, so it can also feed the branch-target adder.
//
// Ports:
//   imm_in    in  IMM_W   raw immediate field
//   ext_mode  in  2       EXT_ZERO / EXT_SIGN / EXT_UPPER, 2'b11 behaves as EXT_SIGN
//   ext_imm   out DATA_W  extended immediate
module alu_srcb_stage_imm_extender
  import alu_srcb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned IMM_W  = DEFAULT_IMM_W
) (
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        ext_mode,
  output logic [DATA_W-1:0] ext_imm
);

  if (DATA_W < IMM_W) begin : g_bad_width
    $error("alu_srcb_stage_imm_extender: DATA_W must be >= IMM_W");
  end

  if (DATA_W == IMM_W) begin : g_same_width
    // No room to extend into: every mode is a straight pass-through.
    logic unused_ext_mode;
    assign unused_ext_mode = ^ext_mode;
    assign ext_imm         = imm_in;
  end else begin : g_extend
    localparam int unsigned UpW = DATA_W - IMM_W;

    logic [DATA_W-1:0] zero_ext;
    logic [DATA_W-1:0] sign_ext;
    logic [DATA_W-1:0] upper_ext;

    assign zero_ext  = {{UpW{1'b0}}, imm_in};
    assign sign_ext  = {{UpW{imm_in[IMM_W-1]}}, imm_in};
    assign upper_ext = {imm_in, {UpW{1'b0}}};

    always_comb begin
      ext_imm = sign_ext;
      unique case (ext_mode)
        EXT_ZERO:  ext_imm = zero_ext;
        EXT_SIGN:  ext_imm = sign_ext;
        EXT_UPPER: ext_imm = upper_ext;
        default:   ext_imm = sign_ext;  // reserved encoding
      endcase
    end
  end

endmodule

// File: rtl/alu_srcb_stage.sv
// EX-stage ALU operand-B select, registered into the EX stage.
//
// Operand B is either the (possibly forwarded) rt value or an extended immediate. The forwarded
// rt value is also registered as store data so loads/stores and ALU ops share this stage.
//
// Ports:
//   clk        in  1               pipeline clock
//   rst_n      in  1               asynchronous active-low reset
//   stall      in  1               hold all registered outputs
//   flush      in  1               insert a bubble (wins over stall)
//   valid_in   in  1               ID-stage instruction valid
//   rd2_in     in  DATA_W          register-file read port 2 value
//   imm_in     in  IMM_W           raw immediate field
//   ext_mode   in  2               immediate extension mode
//   alusrc     in  1               0 = register path, 1 = extended immediate
//   fwd_sel    in  SEL_W           0 = rd2_in, k = fwd_data slice k-1, > NUM_FWD = rd2_in
//   fwd_data   in  NUM_FWD*DATA_W  concatenated forwarded results, slice 0 in the LSBs
//   srcb_out   out DATA_W          registered ALU operand B
//   wdata_out  out DATA_W          registered store data
//   valid_out  out 1               registered valid
module alu_srcb_stage
  import alu_srcb_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned IMM_W   = DEFAULT_IMM_W,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              stall,
  input  logic                              flush,
  input  logic                              valid_in,
  input  logic [DATA_W-1:0]                 rd2_in,
  input  logic [IMM_W-1:0]                  imm_in,
  input  logic [1:0]                        ext_mode,
  input  logic                              alusrc,
  input  logic [$clog2(NUM_FWD+1)-1:0]      fwd_sel,
  input  logic [NUM_FWD*DATA_W-1:0]         fwd_data,
  output logic [DATA_W-1:0]                 srcb_out,
  output logic [DATA_W-1:0]                 wdata_out,
  output logic                              valid_out
);

  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  if (NUM_FWD < 1) begin : g_bad_fwd
    $error("alu_srcb_stage: NUM_FWD must be >= 1");
  end

  // Forward select. Anything other than a valid slice index, including out-of-range
  // selects, falls back to the register-file value so the mux never produces X.
  logic [DATA_W-1:0] fwd_val;

  always_comb begin
    fwd_val = rd2_in;
    if (fwd_sel != SEL_W'(FWD_NONE)) begin
      for (int k = 1; k <= int'(NUM_FWD); k++) begin
        if (fwd_sel == SEL_W'(k)) begin
          fwd_val = fwd_data[(k-1)*DATA_W +: DATA_W];
        end
      end
    end
  end

  logic [DATA_W-1:0] ext_imm;

  alu_srcb_stage_imm_extender #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_imm_extender (
    .imm_in   (imm_in),
    .ext_mode (ext_mode),
    .ext_imm  (ext_imm)
  );

  logic [DATA_W-1:0] srcb_next;
  logic [DATA_W-1:0] wdata_next;

  assign srcb_next  = alusrc ? ext_imm : fwd_val;
  assign wdata_next = fwd_val;

  // Stage registers. Data is captured even for valid_in = 0; consumers qualify by valid_out.
  logic [DATA_W-1:0] srcb_q,  srcb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              valid_q, valid_d;

  always_comb begin
    srcb_d  = srcb_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    if (flush) begin
      srcb_d  = '0;
      wdata_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      srcb_d  = srcb_next;
      wdata_d = wdata_next;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srcb_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      srcb_q  <= srcb_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
    end
  end

  assign srcb_out  = srcb_q;
  assign wdata_out = wdata_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Directed testbench for alu_srcb_stage (default parameters: 32-bit data, 16-bit immediate,
// two forwarding sources).
module tb_alu_srcb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic [31:0] rd2_in;
  logic [15:0] imm_in;
  logic [1:0]  ext_mode;
  logic        alusrc;
  logic [1:0]  fwd_sel;
  logic [63:0] fwd_data;
  logic [31:0] srcb_out;
  logic [31:0] wdata_out;
  logic        valid_out;

  int unsigned checks;
  int unsigned errors;

  alu_srcb_stage #(
    .DATA_W  (32),
    .IMM_W   (16),
    .NUM_FWD (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .valid_in  (valid_in),
    .rd2_in    (rd2_in),
    .imm_in    (imm_in),
    .ext_mode  (ext_mode),
    .alusrc    (alusrc),
    .fwd_sel   (fwd_sel),
    .fwd_data  (fwd_data),
    .srcb_out  (srcb_out),
    .wdata_out (wdata_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fwd_exp [4];

  initial begin
    checks   = 0;
    errors   = 0;
    fwd_exp  = '{32'h11, 32'h22, 32'h33, 32'h11};

    // 1. Reset then release
    rst_n    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b1;
    rd2_in   = 32'h0;
    imm_in   = 16'h8001;
    ext_mode = 2'b01;
    alusrc   = 1'b1;
    fwd_sel  = 2'd0;
    fwd_data = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_srcb",  srcb_out,  32'h0);
    check_eq("rst_wdata", wdata_out, 32'h0);
    check_eq("rst_valid", {31'b0, valid_out}, 32'h0);
    rst_n = 1'b1;
    step();
    check_eq("rel_srcb",  srcb_out, 32'hFFFF8001);
    check_eq("rel_valid", {31'b0, valid_out}, 32'h1);

    // 2. Extension modes
    ext_mode = 2'b00; step(); check_eq("ext_zero",  srcb_out, 32'h00008001);
    ext_mode = 2'b10; step(); check_eq("ext_upper", srcb_out, 32'h80010000);
    ext_mode = 2'b11; step(); check_eq("ext_rsvd",  srcb_out, 32'hFFFF8001);
    imm_in = 16'h7FFF; ext_mode = 2'b01; step(); check_eq("ext_sign_pos", srcb_out, 32'h00007FFF);

    // 3. Forwarding
    alusrc   = 1'b0;
    rd2_in   = 32'h11;
    fwd_data = {32'h33, 32'h22};
    for (int s = 0; s < 4; s++) begin
      fwd_sel = 2'(s);
      step();
      check_eq($sformatf("fwd%0d_srcb", s),  srcb_out,  fwd_exp[s]);
      check_eq($sformatf("fwd%0d_wdata", s), wdata_out, fwd_exp[s]);
    end

    // 4. Store path: immediate operand, forwarded store data
    alusrc   = 1'b1;
    imm_in   = 16'h0004;
    ext_mode = 2'b01;
    fwd_sel  = 2'd1;
    fwd_data = {32'h33, 32'hDEADBEEF};
    step();
    check_eq("st_srcb",  srcb_out,  32'h4);
    check_eq("st_wdata", wdata_out, 32'hDEADBEEF);

    // Bubble without flush still captures data
    valid_in = 1'b0;
    imm_in   = 16'h0008;
    step();
    check_eq("bub_valid", {31'b0, valid_out}, 32'h0);
    check_eq("bub_srcb",  srcb_out, 32'h8);

    // 5. Stall then flush
    valid_in = 1'b1;
    alusrc   = 1'b0;
    fwd_sel  = 2'd1;
    fwd_data = {32'h33, 32'h22};
    step();
    check_eq("cap_srcb", srcb_out, 32'h22);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fwd_sel  = 2'd2;
      rd2_in   = 32'h99 + 32'(c);
      valid_in = c[0];
      alusrc   = 1'b1;
      step();
      check_eq($sformatf("stall%0d_srcb", c),  srcb_out,  32'h22);
      check_eq($sformatf("stall%0d_wdata", c), wdata_out, 32'h22);
      check_eq($sformatf("stall%0d_valid", c), {31'b0, valid_out}, 32'h1);
    end
    flush = 1'b1;
    step();
    check_eq("fl_valid", {31'b0, valid_out}, 32'h0);
    check_eq("fl_srcb",  srcb_out,  32'h0);
    check_eq("fl_wdata", wdata_out, 32'h0);

    // Values present on the release edge are captured
    stall    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b1;
    alusrc   = 1'b0;
    fwd_sel  = 2'd2;
    step();
    check_eq("resume_srcb",  srcb_out, 32'h33);
    check_eq("resume_valid", {31'b0, valid_out}, 32'h1);

    // 6. Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_srcb",  srcb_out,  32'h0);
    check_eq("arst_wdata", wdata_out, 32'h0);
    check_eq("arst_valid", {31'b0, valid_out}, 32'h0);

    // Reset released while stalled: stays 0 until a non-stall edge
    stall = 1'b1;
    #3;
    rst_n = 1'b1;
    step();
    check_eq("rs_stall_srcb",  srcb_out, 32'h0);
    check_eq("rs_stall_valid", {31'b0, valid_out}, 32'h0);
    stall = 1'b0;
    step();
    check_eq("rs_go_srcb",  srcb_out,  32'h33);
    check_eq("rs_go_wdata", wdata_out, 32'h33);
    check_eq("rs_go_valid", {31'b0, valid_out}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
